// File: rtl/bnn_comp_pkg.sv
// rtl/bnn_comp_pkg.sv - shared constants, encoder state and compressed-beat layout
package bnn_comp_pkg;

    localparam int IDX_W       = 6;
    localparam logic [IDX_W-1:0] IDX_SENTINEL = 6'h3F;
    localparam int COMP_WORD_W = 64;
    localparam int COMP_BEAT_W = 3 * IDX_W + COMP_WORD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } enc_state_t;

    // Same layout the accelerator's compressed-write receiver unpacks.
    typedef struct packed {
        logic [IDX_W-1:0]       row;
        logic [IDX_W-1:0]       idx;
        logic [IDX_W-1:0]       ptr;
        logic [COMP_WORD_W-1:0] val;
    } comp_beat_t;

endpackage

// File: rtl/comp_beat_reg.sv
// rtl/comp_beat_reg.sv - single-entry valid/ready register stage for compressed beats
module comp_beat_reg
    import bnn_comp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [COMP_BEAT_W-1:0] s_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [COMP_BEAT_W-1:0] m_tdata
);

    comp_beat_t beat_q;
    logic       valid_q;

    // Refill in the same cycle the held beat drains, giving one beat per cycle.
    assign s_tready = !valid_q || m_tready;
    assign m_tvalid = valid_q;
    assign m_tdata  = beat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (s_tvalid && s_tready) begin
            valid_q <= 1'b1;
            beat_q  <= comp_beat_t'(s_tdata);
        end else if (m_tready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/weight_csr_encoder.sv
// rtl/weight_csr_encoder.sv - dense weight rows to per-row CSR write beats; WEIGHT_ENC_COL_MASK_EN adds column mask
module weight_csr_encoder
    import bnn_comp_pkg::*;
#(
    parameter int WORD_SIZE = COMP_WORD_W,
    parameter int NUM_ROWS  = 64,
    parameter int ROW_LEN   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 wr_compressed,
    input  logic                 out_ready,
    output logic [IDX_W-1:0]     wr_comp_row,
    output logic [IDX_W-1:0]     wr_comp_idx,
    output logic [IDX_W-1:0]     wr_comp_ptr,
    output logic [WORD_SIZE-1:0] wr_comp_val,
    output logic                 row_nnz_valid,
    output logic [IDX_W:0]       row_nnz,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow
`ifdef WEIGHT_ENC_COL_MASK_EN
    ,
    output logic [ROW_LEN-1:0]   active_col_mask,
    output logic [IDX_W:0]       active_col_count
`endif
);

    localparam int NNZ_W = IDX_W + 1;

    enc_state_t       state;
    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] col_cnt;
    logic [IDX_W-1:0] k_cnt;
    logic [NNZ_W-1:0] nnz_cnt;

    logic       beat_s_ready;
    logic       in_fire;
    logic       word_nz;
    logic       last_col;
    logic       last_word;
    logic       overflow_hit;
    logic       out_fire;
    comp_beat_t beat_in;
    comp_beat_t beat_out;

    assign in_ready     = (state == RUN) && beat_s_ready;
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = wr_compressed && out_ready;
    assign word_nz      = (in_data != '0);
    assign last_col     = (col_cnt == IDX_W'(ROW_LEN - 1));
    assign last_word    = last_col && (row_cnt == IDX_W'(NUM_ROWS - 1));
    assign overflow_hit = word_nz && (k_cnt == IDX_SENTINEL);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Zero words and words past the pointer space both become sentinel beats.
    always_comb begin
        beat_in     = '0;
        beat_in.row = row_cnt;
        beat_in.idx = col_cnt;
        beat_in.ptr = IDX_SENTINEL;
        if (word_nz && !overflow_hit) begin
            beat_in.ptr = k_cnt;
            beat_in.val = COMP_WORD_W'(in_data);
        end
    end

    comp_beat_reg u_beat_reg (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (in_fire),
        .s_tready (beat_s_ready),
        .s_tdata  (beat_in),
        .m_tvalid (wr_compressed),
        .m_tready (out_ready),
        .m_tdata  (beat_out)
    );

    assign wr_comp_row = beat_out.row;
    assign wr_comp_idx = beat_out.idx;
    assign wr_comp_ptr = beat_out.ptr;
    assign wr_comp_val = beat_out.val[WORD_SIZE-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            row_cnt       <= '0;
            col_cnt       <= '0;
            k_cnt         <= '0;
            nnz_cnt       <= '0;
            row_nnz_valid <= 1'b0;
            row_nnz       <= '0;
            err_overflow  <= 1'b0;
        end else begin
            row_nnz_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        row_cnt      <= '0;
                        col_cnt      <= '0;
                        k_cnt        <= '0;
                        nnz_cnt      <= '0;
                        err_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        if (overflow_hit) begin
                            err_overflow <= 1'b1;
                        end else if (word_nz) begin
                            k_cnt <= k_cnt + IDX_W'(1);
                        end
                        if (last_col) begin
                            // row_nnz includes dropped overflow words.
                            row_nnz_valid <= 1'b1;
                            row_nnz       <= nnz_cnt + NNZ_W'(word_nz);
                            nnz_cnt       <= '0;
                            k_cnt         <= '0;
                            col_cnt       <= '0;
                            if (last_word) begin
                                row_cnt <= '0;
                                state   <= DRAIN;
                            end else begin
                                row_cnt <= row_cnt + IDX_W'(1);
                            end
                        end else begin
                            nnz_cnt <= nnz_cnt + NNZ_W'(word_nz);
                            col_cnt <= col_cnt + IDX_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_ENC_COL_MASK_EN
    logic [IDX_W:0] mask_pop;

    always_comb begin
        mask_pop = '0;
        for (int c = 0; c < ROW_LEN; c++) begin
            mask_pop = mask_pop + NNZ_W'(active_col_mask[c]);
        end
    end

    // Count is captured on the final handshake so it is valid together with done.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_col_mask  <= '0;
            active_col_count <= '0;
        end else if (state == IDLE && start) begin
            active_col_mask  <= '0;
            active_col_count <= '0;
        end else begin
            if (in_fire && word_nz) begin
                active_col_mask[col_cnt] <= 1'b1;
            end
            if (state == DRAIN && out_fire) begin
                active_col_count <= mask_pop;
            end
        end
    end
`endif

endmodule

// File: tb/tb_weight_csr_encoder.sv
// tb/tb_weight_csr_encoder.sv - scoreboard bench for weight_csr_encoder
module tb_weight_csr_encoder;

    localparam int NUM_ROWS = 64;
    localparam int ROW_LEN  = 64;
    localparam int TOTAL    = NUM_ROWS * ROW_LEN;
    localparam logic [63:0] ALL_ONES = {64{1'b1}};

    logic        clk;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        wr_compressed;
    logic        out_ready;
    logic [5:0]  wr_comp_row;
    logic [5:0]  wr_comp_idx;
    logic [5:0]  wr_comp_ptr;
    logic [63:0] wr_comp_val;
    logic        row_nnz_valid;
    logic [6:0]  row_nnz;
    logic        busy;
    logic        done;
    logic        err_overflow;
`ifdef WEIGHT_ENC_COL_MASK_EN
    logic [63:0] active_col_mask;
    logic [6:0]  active_col_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [81:0] beat_q[$];
    logic [6:0]  nnz_q[$];

    weight_csr_encoder dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .wr_compressed (wr_compressed),
        .out_ready     (out_ready),
        .wr_comp_row   (wr_comp_row),
        .wr_comp_idx   (wr_comp_idx),
        .wr_comp_ptr   (wr_comp_ptr),
        .wr_comp_val   (wr_comp_val),
        .row_nnz_valid (row_nnz_valid),
        .row_nnz       (row_nnz),
        .busy          (busy),
        .done          (done),
        .err_overflow  (err_overflow)
`ifdef WEIGHT_ENC_COL_MASK_EN
        ,
        .active_col_mask  (active_col_mask),
        .active_col_count (active_col_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 0: 75% sparse, 1: 90% sparse, 2: dense row 0 then 75% sparse
    function automatic logic [63:0] word_at(input int pat, input int r, input int c);
        case (pat)
            0: return (c % 4 == 0) ? ALL_ONES : 64'h0;
            1: return (c % 10 == 0 && c < 60) ? (64'h1000_0000_0000_0000 + 64'(r * 256 + c)) : 64'h0;
            default: begin
                if (r == 0) return 64'hA5A5_0000_0000_0001 + 64'(c);
                return (c % 4 == 0) ? ALL_ONES : 64'h0;
            end
        endcase
    endfunction

    function automatic int nz_before(input int pat, input int r, input int c);
        int n = 0;
        for (int j = 0; j < c; j++) begin
            if (word_at(pat, r, j) != 64'h0) n++;
        end
        return n;
    endfunction

    task automatic run_load(input int pat, input int bp, input int abort_at,
                            input int start_at, input logic exp_ovf);
        int in_row = 0, in_col = 0, n_in = 0, n_out = 0, n_rows = 0, n_done = 0, cyc = 0, n;
        logic fin = 1'b0, aborted = 1'b0, stalled = 1'b0;
        logic [81:0] stall_beat = '0, obs, exp_beat;
`ifdef WEIGHT_ENC_COL_MASK_EN
        logic [63:0] exp_mask;
        int exp_cnt;
`endif
        beat_q.delete();
        nnz_q.delete();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("busy_after_start", busy, 1'b1);
        check_eq("ovf_clear_on_start", err_overflow, 1'b0);
        while (!fin && cyc < 20000) begin
            out_ready = (bp == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            in_valid  = (n_in < TOTAL);
            in_data   = word_at(pat, in_row, in_col);
            start     = (cyc == start_at);
            if (n_in == abort_at) begin
                in_valid = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                #1;
                check_eq("abort_wr_compressed", wr_compressed, 1'b0);
                check_eq("abort_busy", busy, 1'b0);
                reset = 1'b0;
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                #1;
                obs = {wr_comp_row, wr_comp_idx, wr_comp_ptr, wr_comp_val};
                if (stalled) check_eq("stall_hold", {wr_compressed, obs}, {1'b1, stall_beat});
                if (row_nnz_valid) begin
                    n_rows++;
                    if (nnz_q.size() == 0) check_eq("row_nnz_extra", row_nnz_valid, 1'b0);
                    else check_eq("row_nnz", row_nnz, nnz_q.pop_front());
                end
                if (done) begin
                    n_done++;
                    fin = 1'b1;
                    check_eq("beats_at_done", n_out, TOTAL);
                    check_eq("rows_at_done", n_rows, NUM_ROWS);
                    check_eq("queue_empty_at_done", beat_q.size(), 0);
                    check_eq("ovf_at_done", err_overflow, exp_ovf);
                    check_eq("busy_at_done", busy, 1'b1);
`ifdef WEIGHT_ENC_COL_MASK_EN
                    exp_mask = '0;
                    exp_cnt = 0;
                    for (int r = 0; r < NUM_ROWS; r++)
                        for (int c = 0; c < ROW_LEN; c++)
                            if (word_at(pat, r, c) != 64'h0) exp_mask[c] = 1'b1;
                    for (int c = 0; c < ROW_LEN; c++) exp_cnt += int'(exp_mask[c]);
                    check_eq("col_mask", active_col_mask, exp_mask);
                    check_eq("col_count", active_col_count, exp_cnt);
`endif
                end
                stalled = wr_compressed && !out_ready;
                stall_beat = obs;
                if (stalled) check_eq("in_ready_stall", in_ready, 1'b0);
                if (in_valid && in_ready) begin
                    n = nz_before(pat, in_row, in_col);
                    if (in_data != 64'h0 && n < 63)
                        exp_beat = {6'(in_row), 6'(in_col), 6'(n), in_data};
                    else
                        exp_beat = {6'(in_row), 6'(in_col), 6'h3F, 64'h0};
                    beat_q.push_back(exp_beat);
                    if (in_col == ROW_LEN - 1) begin
                        nnz_q.push_back(7'(nz_before(pat, in_row, ROW_LEN)));
                        in_col = 0;
                        in_row++;
                    end else begin
                        in_col++;
                    end
                    n_in++;
                end
                if (wr_compressed && out_ready) begin
                    if (beat_q.size() == 0) check_eq("beat_extra", wr_compressed, 1'b0);
                    else check_eq("beat", obs, beat_q.pop_front());
                    n_out++;
                end
                cyc++;
                @(negedge clk);
            end
        end
        if (!aborted) begin
            check_eq("done_seen", fin, 1'b1);
            in_valid = 1'b0;
            out_ready = 1'b1;
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                if (done) n_done++;
                @(negedge clk);
            end
            #1;
            check_eq("done_pulses", n_done, 1);
            check_eq("idle_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_wr_compressed", wr_compressed, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_err_overflow", err_overflow, 1'b0);
        check_eq("rst_row_nnz", {row_nnz_valid, row_nnz}, 8'h0);
        check_eq("rst_beat", {wr_comp_row, wr_comp_idx, wr_comp_ptr, wr_comp_val}, 82'h0);
        reset = 1'b0;

        run_load(0, 0, -1, -1, 1'b0);
        run_load(1, 0, -1, -1, 1'b0);
        run_load(2, 0, -1, -1, 1'b1);
        run_load(0, 1, -1, -1, 1'b0);
        run_load(0, 0, 10 * ROW_LEN + 5, -1, 1'b0);
        run_load(1, 0, -1, -1, 1'b0);
        run_load(0, 0, -1, 100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
